// File: rtl/decode_pkg.sv
// Shared RV32 decode definitions: opcodes, flag indices, system words,
// immediate formats and the queued entry layout.
package decode_pkg;

  localparam int unsigned FLG_W_MAX = 56;

  // Major opcode field instr[6:2]
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam int unsigned FLG_BEQ    = 0;
  localparam int unsigned FLG_BGE    = 1;
  localparam int unsigned FLG_BGEU   = 2;
  localparam int unsigned FLG_BLT    = 3;
  localparam int unsigned FLG_BLTU   = 4;
  localparam int unsigned FLG_BNE    = 5;
  localparam int unsigned FLG_JALR   = 6;
  localparam int unsigned FLG_JAL    = 7;
  localparam int unsigned FLG_AUIPC  = 8;
  localparam int unsigned FLG_ADDI   = 9;
  localparam int unsigned FLG_ANDI   = 10;
  localparam int unsigned FLG_ORI    = 11;
  localparam int unsigned FLG_SLLI   = 12;
  localparam int unsigned FLG_SLTI   = 13;
  localparam int unsigned FLG_SLTIU  = 14;
  localparam int unsigned FLG_SRAI   = 15;
  localparam int unsigned FLG_SRLI   = 16;
  localparam int unsigned FLG_XORI   = 17;
  localparam int unsigned FLG_ADD    = 18;
  localparam int unsigned FLG_AND    = 19;
  localparam int unsigned FLG_OR     = 20;
  localparam int unsigned FLG_SLL    = 21;
  localparam int unsigned FLG_SLT    = 22;
  localparam int unsigned FLG_SLTU   = 23;
  localparam int unsigned FLG_SRA    = 24;
  localparam int unsigned FLG_SRL    = 25;
  localparam int unsigned FLG_SUB    = 26;
  localparam int unsigned FLG_XOR    = 27;
  localparam int unsigned FLG_LUI    = 28;
  localparam int unsigned FLG_LB     = 29;
  localparam int unsigned FLG_LBU    = 30;
  localparam int unsigned FLG_LH     = 31;
  localparam int unsigned FLG_LHU    = 32;
  localparam int unsigned FLG_LW     = 33;
  localparam int unsigned FLG_SB     = 34;
  localparam int unsigned FLG_SH     = 35;
  localparam int unsigned FLG_SW     = 36;
  localparam int unsigned FLG_CSRRC  = 37;
  localparam int unsigned FLG_CSRRCI = 38;
  localparam int unsigned FLG_CSRRS  = 39;
  localparam int unsigned FLG_CSRRSI = 40;
  localparam int unsigned FLG_CSRRW  = 41;
  localparam int unsigned FLG_CSRRWI = 42;
  localparam int unsigned FLG_EBREAK = 43;
  localparam int unsigned FLG_ECALL  = 44;
  localparam int unsigned FLG_MRET   = 45;
  localparam int unsigned FLG_SRET   = 46;
  localparam int unsigned FLG_WFI    = 47;
  localparam int unsigned FLG_MUL    = 48;
  localparam int unsigned FLG_MULH   = 49;
  localparam int unsigned FLG_MULHSU = 50;
  localparam int unsigned FLG_MULHU  = 51;
  localparam int unsigned FLG_DIV    = 52;
  localparam int unsigned FLG_DIVU   = 53;
  localparam int unsigned FLG_REM    = 54;
  localparam int unsigned FLG_REMU   = 55;

  localparam logic [31:0] SYS_ECALL  = 32'h0000_0073;
  localparam logic [31:0] SYS_EBREAK = 32'h0010_0073;
  localparam logic [31:0] SYS_MRET   = 32'h3020_0073;
  localparam logic [31:0] SYS_SRET   = 32'h1020_0073;
  localparam logic [31:0] SYS_WFI    = 32'h1050_0073;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR, FMT_NONE
  } imm_fmt_t;

  // Queue entry fields other than the parameter-width flag vector
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        invalid;
  } decode_meta_t;

  function automatic logic [31:0] imm_gen(input imm_fmt_t fmt, input logic [31:0] i);
    case (fmt)
      FMT_I:   return {{20{i[31]}}, i[31:20]};
      FMT_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   return {i[31:12], 12'b0};
      FMT_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      FMT_CSR: return {20'b0, i[31:20]};
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// Synchronous FIFO with flush; read data forced to zero while empty.
module decode_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I/Zicsr/privileged (+optional M) decode stage with a buffered
// valid/ready output queue and a saturating illegal-word counter.
module rv_decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned EN_M   = 0,
  parameter int unsigned STRICT = 1,
  parameter int unsigned FLAG_W = 48 + 8 * EN_M
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [XLEN-1:0]   out_imm,
  output logic [FLAG_W-1:0] out_flags,
  output logic              out_invalid,
  output logic [15:0]       illegal_cnt
);

  localparam int unsigned DEC_W  = FLAG_W + XLEN + 1;
  localparam int unsigned META_W = $bits(decode_meta_t);
  localparam int unsigned DATA_W = FLAG_W + META_W;

  // Returns {invalid, imm, flags}; illegal words carry zero imm and flags
  function automatic logic [DEC_W-1:0] decode(input logic [31:0] ins);
    logic [FLG_W_MAX-1:0] fl;
    logic                 ill;
    imm_fmt_t             fmt;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic                 f7_zero;
    logic                 alt_ok;
    logic                 alt;
    fl  = '0;
    ill = 1'b0;
    fmt = FMT_NONE;
    f3  = ins[14:12];
    f7  = ins[31:25];
    if (STRICT != 0) begin
      f7_zero = (f7 == 7'h00);
      alt_ok  = (f7 == 7'h00) || (f7 == 7'h20);
      alt     = (f7 == 7'h20);
    end else begin
      f7_zero = 1'b1;
      alt_ok  = 1'b1;
      alt     = ins[30];
    end

    if (ins == 32'h0) begin
      ill = (STRICT != 0);
    end else if (ins[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (ins[6:2])
        OPC_LUI:   begin fl[FLG_LUI] = 1'b1;   fmt = FMT_U; end
        OPC_AUIPC: begin fl[FLG_AUIPC] = 1'b1; fmt = FMT_U; end
        OPC_JAL:   begin fl[FLG_JAL] = 1'b1;   fmt = FMT_J; end
        OPC_JALR: begin
          fmt = FMT_I;
          if (f3 == 3'b000) fl[FLG_JALR] = 1'b1;
          else              ill = 1'b1;
        end
        OPC_BRANCH: begin
          fmt = FMT_B;
          case (f3)
            3'b000:  fl[FLG_BEQ]  = 1'b1;
            3'b001:  fl[FLG_BNE]  = 1'b1;
            3'b100:  fl[FLG_BLT]  = 1'b1;
            3'b101:  fl[FLG_BGE]  = 1'b1;
            3'b110:  fl[FLG_BLTU] = 1'b1;
            3'b111:  fl[FLG_BGEU] = 1'b1;
            default: ill = 1'b1;
          endcase
        end
        OPC_LOAD: begin
          fmt = FMT_I;
          case (f3)
            3'b000:  fl[FLG_LB]  = 1'b1;
            3'b001:  fl[FLG_LH]  = 1'b1;
            3'b010:  fl[FLG_LW]  = 1'b1;
            3'b100:  fl[FLG_LBU] = 1'b1;
            3'b101:  fl[FLG_LHU] = 1'b1;
            default: ill = 1'b1;
          endcase
        end
        OPC_STORE: begin
          fmt = FMT_S;
          case (f3)
            3'b000:  fl[FLG_SB] = 1'b1;
            3'b001:  fl[FLG_SH] = 1'b1;
            3'b010:  fl[FLG_SW] = 1'b1;
            default: ill = 1'b1;
          endcase
        end
        OPC_OPIMM: begin
          fmt = FMT_I;
          case (f3)
            3'b000: fl[FLG_ADDI]  = 1'b1;
            3'b010: fl[FLG_SLTI]  = 1'b1;
            3'b011: fl[FLG_SLTIU] = 1'b1;
            3'b100: fl[FLG_XORI]  = 1'b1;
            3'b110: fl[FLG_ORI]   = 1'b1;
            3'b111: fl[FLG_ANDI]  = 1'b1;
            3'b001: begin
              if (f7_zero) fl[FLG_SLLI] = 1'b1;
              else         ill = 1'b1;
            end
            default: begin
              if (!alt_ok)  ill = 1'b1;
              else if (alt) fl[FLG_SRAI] = 1'b1;
              else          fl[FLG_SRLI] = 1'b1;
            end
          endcase
        end
        OPC_OP: begin
          fmt = FMT_R;
          if (f7 == 7'h01) begin
            if (EN_M != 0) begin
              case (f3)
                3'b000:  fl[FLG_MUL]    = 1'b1;
                3'b001:  fl[FLG_MULH]   = 1'b1;
                3'b010:  fl[FLG_MULHSU] = 1'b1;
                3'b011:  fl[FLG_MULHU]  = 1'b1;
                3'b100:  fl[FLG_DIV]    = 1'b1;
                3'b101:  fl[FLG_DIVU]   = 1'b1;
                3'b110:  fl[FLG_REM]    = 1'b1;
                default: fl[FLG_REMU]   = 1'b1;
              endcase
            end else begin
              ill = 1'b1;
            end
          end else begin
            case (f3)
              3'b000: begin
                if (!alt_ok)  ill = 1'b1;
                else if (alt) fl[FLG_SUB] = 1'b1;
                else          fl[FLG_ADD] = 1'b1;
              end
              3'b101: begin
                if (!alt_ok)  ill = 1'b1;
                else if (alt) fl[FLG_SRA] = 1'b1;
                else          fl[FLG_SRL] = 1'b1;
              end
              3'b001:  if (f7_zero) fl[FLG_SLL]  = 1'b1; else ill = 1'b1;
              3'b010:  if (f7_zero) fl[FLG_SLT]  = 1'b1; else ill = 1'b1;
              3'b011:  if (f7_zero) fl[FLG_SLTU] = 1'b1; else ill = 1'b1;
              3'b100:  if (f7_zero) fl[FLG_XOR]  = 1'b1; else ill = 1'b1;
              3'b110:  if (f7_zero) fl[FLG_OR]   = 1'b1; else ill = 1'b1;
              default: if (f7_zero) fl[FLG_AND]  = 1'b1; else ill = 1'b1;
            endcase
          end
        end
        OPC_SYSTEM: begin
          if (f3 == 3'b000) begin
            case (ins)
              SYS_ECALL:  fl[FLG_ECALL]  = 1'b1;
              SYS_EBREAK: fl[FLG_EBREAK] = 1'b1;
              SYS_MRET:   fl[FLG_MRET]   = 1'b1;
              SYS_SRET:   fl[FLG_SRET]   = 1'b1;
              SYS_WFI:    fl[FLG_WFI]    = 1'b1;
              default:    ill = 1'b1;
            endcase
          end else begin
            fmt = FMT_CSR;
            case (f3)
              3'b001:  fl[FLG_CSRRW]  = 1'b1;
              3'b010:  fl[FLG_CSRRS]  = 1'b1;
              3'b011:  fl[FLG_CSRRC]  = 1'b1;
              3'b101:  fl[FLG_CSRRWI] = 1'b1;
              3'b110:  fl[FLG_CSRRSI] = 1'b1;
              3'b111:  fl[FLG_CSRRCI] = 1'b1;
              default: ill = 1'b1;
            endcase
          end
        end
        default: ill = 1'b1;
      endcase
    end

    if (ill) return {1'b1, XLEN'(0), FLAG_W'(0)};
    return {1'b0, XLEN'(imm_gen(fmt, ins)), FLAG_W'(fl)};
  endfunction

  logic [FLAG_W-1:0]       dec_flags;
  logic [XLEN-1:0]         dec_imm;
  logic                    dec_invalid;
  logic                    wr_fire;
  logic                    fifo_full;
  logic [$clog2(DEPTH):0]  fifo_count;
  decode_meta_t            wr_meta;
  decode_meta_t            head_meta;
  logic [DATA_W-1:0]       wr_data;
  logic [DATA_W-1:0]       rd_data;

  assign {dec_invalid, dec_imm, dec_flags} = decode(in_instr);

  always_comb begin
    wr_meta         = '0;
    wr_meta.pc      = 32'(in_pc);
    wr_meta.rd      = in_instr[11:7];
    wr_meta.rs1     = in_instr[19:15];
    wr_meta.rs2     = in_instr[24:20];
    wr_meta.imm     = 32'(dec_imm);
    wr_meta.invalid = dec_invalid;
  end

  assign wr_data  = {dec_flags, wr_meta};
  assign in_ready = !fifo_full;
  assign wr_fire  = in_valid && in_ready && !flush;

  decode_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (wr_fire),
    .wr_data (wr_data),
    .rd_en   (out_ready),
    .rd_data (rd_data),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign head_meta   = decode_meta_t'(rd_data[META_W-1:0]);
  assign out_valid   = (fifo_count != '0);
  assign out_flags   = rd_data[DATA_W-1 -: FLAG_W];
  assign out_pc      = XLEN'(head_meta.pc);
  assign out_rd      = head_meta.rd;
  assign out_rs1     = head_meta.rs1;
  assign out_rs2     = head_meta.rs2;
  assign out_imm     = XLEN'(head_meta.imm);
  assign out_invalid = head_meta.invalid;

  // Saturating; survives flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (wr_fire && dec_invalid && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: a default build (EN_M=0, STRICT=1)
// and an M-enabled relaxed build driven with identical stimulus.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  logic        in_ready_a, out_valid_a, inv_a;
  logic [31:0] pc_a, imm_a;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [47:0] flags_a;
  logic [15:0] cnt_a;

  logic        in_ready_b, out_valid_b, inv_b;
  logic [31:0] pc_b, imm_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;
  logic [55:0] flags_b;
  logic [15:0] cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rv_decode_stage dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(pc_a),
    .out_rd(rd_a), .out_rs1(rs1_a), .out_rs2(rs2_a), .out_imm(imm_a),
    .out_flags(flags_a), .out_invalid(inv_a), .illegal_cnt(cnt_a)
  );

  rv_decode_stage #(.EN_M(1), .STRICT(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(pc_b),
    .out_rd(rd_b), .out_rs1(rs1_b), .out_rs2(rs2_b), .out_imm(imm_b),
    .out_flags(flags_b), .out_invalid(inv_b), .illegal_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fexp(input int k);
    return (k < 0) ? 64'd0 : (64'd1 << k);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    int          fa;
    logic        ia;
    int          fb;
    logic        ib;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;

    // instr, flag A, invalid A, flag B, invalid B, imm (-1 = no flag)
    vecs.push_back('{32'h00500093,  9, 1'b0,  9, 1'b0, 32'h0000_0005}); // addi
    vecs.push_back('{32'hFE000EE3,  0, 1'b0,  0, 1'b0, 32'hFFFF_FFFC}); // beq -4
    vecs.push_back('{32'h00100073, 43, 1'b0, 43, 1'b0, 32'h0});         // ebreak
    vecs.push_back('{32'h022080B3, -1, 1'b1, 48, 1'b0, 32'h0});         // mul
    vecs.push_back('{32'h00000000, -1, 1'b1, -1, 1'b0, 32'h0});         // zero word
    vecs.push_back('{32'h4000D093, 15, 1'b0, 15, 1'b0, 32'h0000_0400}); // srai
    vecs.push_back('{32'h3002E0F3, 40, 1'b0, 40, 1'b0, 32'h0000_0300}); // csrrsi
    vecs.push_back('{32'h0000B003, -1, 1'b1, -1, 1'b1, 32'h0});         // load f3=011
    vecs.push_back('{32'h40208033, 26, 1'b0, 26, 1'b0, 32'h0});         // sub
    vecs.push_back('{32'h123450B7, 28, 1'b0, 28, 1'b0, 32'h1234_5000}); // lui
    vecs.push_back('{32'h0080006F,  7, 1'b0,  7, 1'b0, 32'h0000_0008}); // jal +8
    vecs.push_back('{32'hFE20AC23, 36, 1'b0, 36, 1'b0, 32'hFFFF_FFF8}); // sw -8
    vecs.push_back('{32'h04208033, -1, 1'b1, 18, 1'b0, 32'h0});         // add, odd funct7
    vecs.push_back('{32'h30200073, 45, 1'b0, 45, 1'b0, 32'h0});         // mret
    vecs.push_back('{32'h00200073, -1, 1'b1, -1, 1'b1, 32'h0});         // bad system word

    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 64'(out_valid_a), 64'd0);
    check("rst in_ready", 64'(in_ready_a), 64'd1);
    check("rst illegal_cnt", 64'(cnt_a), 64'd0);
    check("rst flags", 64'(flags_a), 64'd0);
    check("rst pc", 64'(pc_a), 64'd0);
    rst = 1'b0;
    step();
    check("post-rst out_valid", 64'(out_valid_a), 64'd0);

    foreach (vecs[i]) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h100 + 32'(i) * 4;
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d out_valid", i), 64'(out_valid_a), 64'd1);
      check($sformatf("v%0d flags_a", i), 64'(flags_a), fexp(vecs[i].fa));
      check($sformatf("v%0d invalid_a", i), 64'(inv_a), 64'(vecs[i].ia));
      check($sformatf("v%0d imm_a", i), 64'(imm_a), 64'(vecs[i].imm));
      check($sformatf("v%0d pc_a", i), 64'(pc_a), 64'(32'h100 + 32'(i) * 4));
      check($sformatf("v%0d regs_a", i), 64'({rd_a, rs1_a, rs2_a}),
            64'({vecs[i].instr[11:7], vecs[i].instr[19:15], vecs[i].instr[24:20]}));
      check($sformatf("v%0d flags_b", i), 64'(flags_b), fexp(vecs[i].fb));
      check($sformatf("v%0d invalid_b", i), 64'(inv_b), 64'(vecs[i].ib));
      check($sformatf("v%0d imm_b", i), 64'(imm_b), 64'(vecs[i].imm));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("v%0d drained", i), 64'(out_valid_a), 64'd0);
    end
    check("illegal_cnt a", 64'(cnt_a), 64'd5);
    check("illegal_cnt b", 64'(cnt_b), 64'd2);

    // Back-pressure: DEPTH+1 words offered with execute stalled
    in_valid = 1'b1;
    in_instr = 32'h00100093;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h1000 + 32'(i) * 4;
      step();
      check($sformatf("stall%0d in_ready", i), 64'(in_ready_a), 64'(i == 0));
      check($sformatf("stall%0d head pc", i), 64'(pc_a), 64'h1000);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("drain0 pc", 64'(pc_a), 64'h1000);
    step();
    check("drain in_ready back", 64'(in_ready_a), 64'd1);
    check("drain1 pc", 64'(pc_a), 64'h1004);
    check("drain1 valid", 64'(out_valid_a), 64'd1);
    step();
    check("drain no extra", 64'(out_valid_a), 64'd0);
    out_ready = 1'b0;

    // Simultaneous read and write keeps one entry in flight, in order
    in_valid = 1'b1; in_pc = 32'h3000;
    step();
    out_ready = 1'b1; in_pc = 32'h3004;
    step();
    check("rw1 pc", 64'(pc_a), 64'h3004);
    check("rw1 valid", 64'(out_valid_a), 64'd1);
    check("rw1 in_ready", 64'(in_ready_a), 64'd1);
    in_pc = 32'h3008;
    step();
    check("rw2 pc", 64'(pc_a), 64'h3008);
    in_valid = 1'b0;
    step();
    check("rw empty", 64'(out_valid_a), 64'd0);
    out_ready = 1'b0;

    // Flush a full queue while an illegal word is offered
    in_valid = 1'b1; in_pc = 32'h4000;
    step();
    in_pc = 32'h4004;
    step();
    check("pre-flush full", 64'(in_ready_a), 64'd0);
    flush = 1'b1; in_instr = 32'h0000B003; in_pc = 32'h4008; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush out_valid", 64'(out_valid_a), 64'd0);
    check("flush in_ready", 64'(in_ready_a), 64'd1);
    check("flush pc zero", 64'(pc_a), 64'd0);
    check("flush cnt a", 64'(cnt_a), 64'd5);
    check("flush cnt b", 64'(cnt_b), 64'd2);
    step();
    check("flushed word absent", 64'(out_valid_a), 64'd0);

    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h5000;
    step();
    in_valid = 1'b0;
    check("post-flush pc", 64'(pc_a), 64'h5000);

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    check("async rst out_valid", 64'(out_valid_a), 64'd0);
    check("async rst cnt", 64'(cnt_a), 64'd0);
    check("async rst in_ready", 64'(in_ready_a), 64'd1);
    check("async rst pc", 64'(pc_a), 64'd0);
    step();
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
